dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported data memory between the RV32I core's load/store path and a debug/loader port used for memory preload and dump. It sits between the core's data-memory interface and the data memory instance. It grants one access at a time with two-way round-robin on conflict. It stalls the core while its access is pending and returns read data one cycle after grant.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_arbiter_rr_arb2.sv | 22 ++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// port identifiers and the saturating access-counter helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DBG = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int   CNT_W    = 16;

  // Counters stick at all-ones rather than wrapping back to zero
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic             en);
    logic [CNT_W-1:0] res;
    res = val;
    if (en && (val != {CNT_W{1'b1}})) begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker: on a tie the port that did not win last time
// is chosen. Purely combinational; the history bit lives in the parent.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // One-hot pick from the request vector and the previous winner
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == PORT_DBG) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous data memory between the core load/store path and the
// debug/loader port. Optional grant/conflict counters: DMEM_ARB_ACCESS_CNT_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              top_clk,
  input  logic              top_rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [3:0]        dbg_wstrb,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_ACCESS_CNT_EN
  ,
  output logic [CNT_W-1:0]  cpu_gnt_cnt,
  output logic [CNT_W-1:0]  dbg_gnt_cnt,
  output logic [CNT_W-1:0]  conflict_cnt
`endif
);

  arb_state_e        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic              cpu_rvalid_q, dbg_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [1:0]        req_s, pick_s;
  logic              idle_s;
  logic              unused_addr_lsb_s;

  assign unused_addr_lsb_s = ^{cpu_addr[1:0], dbg_addr[1:0]};

  assign req_s = {dbg_req, cpu_req};

  rr_arb2 u_rr_arb2 (
    .req      (req_s),
    .last_gnt (last_gnt_q),
    .gnt      (pick_s)
  );

  // Grants are gated by reset so every output reads zero while reset is held
  assign idle_s  = (state_q == IDLE) & top_rst_n;
  assign cpu_gnt = idle_s & pick_s[0];
  assign dbg_gnt = idle_s & pick_s[1];

  // Memory strobes, next state and round-robin history from the current grant
  always_comb begin
    mem_en     = 1'b0;
    mem_we     = 4'h0;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    if (cpu_gnt) begin
      mem_en     = 1'b1;
      mem_we     = cpu_we ? cpu_wstrb : 4'h0;
      mem_addr   = {cpu_addr[ADDR_W-1:2], 2'b00};
      mem_wdata  = cpu_wdata;
      last_gnt_d = PORT_CPU;
      state_d    = cpu_we ? IDLE : RD_CPU;
    end else if (dbg_gnt) begin
      mem_en     = 1'b1;
      mem_we     = dbg_we ? dbg_wstrb : 4'h0;
      mem_addr   = {dbg_addr[ADDR_W-1:2], 2'b00};
      mem_wdata  = dbg_wdata;
      last_gnt_d = PORT_DBG;
      state_d    = dbg_we ? IDLE : RD_DBG;
    end else begin
      case (state_q)
        RD_CPU:  state_d = IDLE;
        RD_DBG:  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM, history bit, read-valid flags and held read data
  always_ff @(posedge top_clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      state_q      <= IDLE;
      last_gnt_q   <= PORT_DBG;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= {DATA_W{1'b0}};
      dbg_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
      if (state_q == RD_CPU) begin
        cpu_rdata_q <= mem_rdata;
      end
      if (state_q == RD_DBG) begin
        dbg_rdata_q <= mem_rdata;
      end
    end
  end

  // Memory data only arrives in the return cycle, so it passes straight through
  // there and is held from the register afterwards.
  assign cpu_rvalid = cpu_rvalid_q;
  assign dbg_rvalid = dbg_rvalid_q;
  assign cpu_rdata  = (state_q == RD_CPU) ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata  = (state_q == RD_DBG) ? mem_rdata : dbg_rdata_q;
  assign cpu_stall  = top_rst_n & cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid_q;

`ifdef DMEM_ARB_ACCESS_CNT_EN
  logic [CNT_W-1:0] cpu_cnt_q, dbg_cnt_q, conf_cnt_q;

  // Saturating grant and conflict counters
  always_ff @(posedge top_clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      cpu_cnt_q  <= {CNT_W{1'b0}};
      dbg_cnt_q  <= {CNT_W{1'b0}};
      conf_cnt_q <= {CNT_W{1'b0}};
    end else begin
      cpu_cnt_q  <= sat_inc(cpu_cnt_q, cpu_gnt);
      dbg_cnt_q  <= sat_inc(dbg_cnt_q, dbg_gnt);
      conf_cnt_q <= sat_inc(conf_cnt_q, idle_s & cpu_req & dbg_req);
    end
  end

  assign cpu_gnt_cnt  = cpu_cnt_q;
  assign dbg_gnt_cnt  = dbg_cnt_q;
  assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req   [2];
  logic        a_we    [2];
  logic [31:0] a_addr  [2];
  logic [31:0] a_wdata [2];
  logic [3:0]  a_wstrb [2];

  logic        cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, cpu_stall, mem_en;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] dmem [64] = '{default: 32'h0};

  int          n_tests = 0;
  int          n_fail  = 0;

  // reference model: owner of the read returning this cycle, tie history, memory image
  int          rd_owner;
  int          last_w;
  logic [31:0] rd_val;
  logic [31:0] exp_rdata [2];
  logic [31:0] ref_mem [64];
  logic        done [2];
  int          m_cpu_cnt, m_dbg_cnt, m_conf_cnt;

  always #5 clk = ~clk;

`ifdef DMEM_ARB_ACCESS_CNT_EN
  logic [15:0] cpu_gnt_cnt, dbg_gnt_cnt, conflict_cnt;
`endif

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .top_clk    (clk),
    .top_rst_n  (rst_n),
    .cpu_req    (a_req[0]),
    .cpu_we     (a_we[0]),
    .cpu_addr   (a_addr[0]),
    .cpu_wdata  (a_wdata[0]),
    .cpu_wstrb  (a_wstrb[0]),
    .dbg_req    (a_req[1]),
    .dbg_we     (a_we[1]),
    .dbg_addr   (a_addr[1]),
    .dbg_wdata  (a_wdata[1]),
    .dbg_wstrb  (a_wstrb[1]),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .dbg_gnt    (dbg_gnt),
    .dbg_rvalid (dbg_rvalid),
    .dbg_rdata  (dbg_rdata),
    .cpu_stall  (cpu_stall),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_ACCESS_CNT_EN
    ,
    .cpu_gnt_cnt  (cpu_gnt_cnt),
    .dbg_gnt_cnt  (dbg_gnt_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // synchronous single-port data memory driven by the DUT
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'h0) begin
        mem_rdata <= dmem[mem_addr[7:2]];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) dmem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic req, input logic we,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws);
    a_req[p]   = req;
    a_we[p]    = we;
    a_addr[p]  = addr;
    a_wdata[p] = wd;
    a_wstrb[p] = ws;
  endtask

  // Called at a negedge with inputs already driven: predict, compare, advance, wait.
  task automatic step();
    int          w;
    logic        e_rv0, e_rv1;
    logic [31:0] e_rd0, e_rd1, e_addr, e_wd;
    logic [3:0]  e_we;
    #1;
    done[0] = 1'b0;
    done[1] = 1'b0;
    w       = -1;
    e_rv0   = 1'b0;
    e_rv1   = 1'b0;
    e_rd0   = 32'h0;
    e_rd1   = 32'h0;
    e_addr  = 32'h0;
    e_wd    = 32'h0;
    e_we    = 4'h0;
    if (!rst_n) begin
      rd_owner     = -1;
      last_w       = 1;
      exp_rdata[0] = 32'h0;
      exp_rdata[1] = 32'h0;
    end else begin
      e_rv0 = (rd_owner == 0);
      e_rv1 = (rd_owner == 1);
      e_rd0 = e_rv0 ? rd_val : exp_rdata[0];
      e_rd1 = e_rv1 ? rd_val : exp_rdata[1];
      if (rd_owner < 0) begin
        if (a_req[0] && a_req[1]) begin
          w = 1 - last_w;
          m_conf_cnt++;
        end else if (a_req[0]) w = 0;
        else if (a_req[1]) w = 1;
      end
      if (w >= 0) begin
        e_addr = {a_addr[w][31:2], 2'b00};
        e_wd   = a_wdata[w];
        e_we   = a_we[w] ? a_wstrb[w] : 4'h0;
      end
    end
    chk("cpu_gnt",    {31'h0, cpu_gnt},    {31'h0, (w == 0)});
    chk("dbg_gnt",    {31'h0, dbg_gnt},    {31'h0, (w == 1)});
    chk("mem_en",     {31'h0, mem_en},     {31'h0, (w >= 0)});
    chk("mem_we",     {28'h0, mem_we},     {28'h0, e_we});
    chk("mem_addr",   mem_addr,            e_addr);
    chk("mem_wdata",  mem_wdata,           e_wd);
    chk("cpu_rvalid", {31'h0, cpu_rvalid}, {31'h0, e_rv0});
    chk("dbg_rvalid", {31'h0, dbg_rvalid}, {31'h0, e_rv1});
    chk("cpu_rdata",  cpu_rdata,           e_rd0);
    chk("dbg_rdata",  dbg_rdata,           e_rd1);
    chk("cpu_stall",  {31'h0, cpu_stall},
        {31'h0, rst_n & a_req[0] & ~((w == 0) & a_we[0]) & ~e_rv0});
    if (rst_n) begin
      if (rd_owner >= 0) begin
        exp_rdata[rd_owner] = rd_val;
        done[rd_owner]      = 1'b1;
      end
      rd_owner = -1;
      if (w >= 0) begin
        last_w = w;
        if (w == 0) m_cpu_cnt++;
        else m_dbg_cnt++;
        if (a_we[w]) begin
          for (int b = 0; b < 4; b++) begin
            if (a_wstrb[w][b]) ref_mem[a_addr[w][7:2]][8*b +: 8] = a_wdata[w][8*b +: 8];
          end
          done[w] = 1'b1;
        end else begin
          rd_owner = w;
          rd_val   = ref_mem[a_addr[w][7:2]];
        end
      end
    end
    @(negedge clk);
  endtask

  // Random requester behaviour: finish, occasionally withdraw, start new accesses
  task automatic drive_random();
    logic withdrew;
    for (int p = 0; p < 2; p++) begin
      withdrew = 1'b0;
      if (a_req[p]) begin
        if (done[p]) a_req[p] = 1'b0;
        else if (rd_owner != p && $urandom_range(15) == 0) begin
          a_req[p] = 1'b0;
          withdrew = 1'b1;
        end
      end
      if (!a_req[p] && !withdrew && $urandom_range(3) != 0) begin
        set_port(p, 1'b1, 1'($urandom_range(1)), $urandom, $urandom, 4'($urandom_range(15)));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    rd_owner   = -1;
    last_w     = 1;
    rd_val     = 32'h0;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    m_cpu_cnt  = 0;
    m_dbg_cnt  = 0;
    m_conf_cnt = 0;
    rst_n = 1'b0;
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;

    // CPU write, same-cycle grant
    set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1;
    chk("wr_gnt", {31'h0, cpu_gnt}, 32'h1);
    chk("wr_mem_we", {28'h0, mem_we}, 32'hF);
    chk("wr_addr", mem_addr, 32'h10);
    chk("wr_stall", {31'h0, cpu_stall}, 32'h0);
    step();
    a_req[0] = 1'b0;
    step();

    // CPU read of unaligned address
    set_port(0, 1'b1, 1'b0, 32'h12, 32'h0, 4'h0);
    #1;
    chk("rd_addr", mem_addr, 32'h10);
    chk("rd_stall_n", {31'h0, cpu_stall}, 32'h1);
    step();
    #1;
    chk("rd_rvalid", {31'h0, cpu_rvalid}, 32'h1);
    chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rd_stall_n1", {31'h0, cpu_stall}, 32'h0);
    step();
    a_req[0] = 1'b0;
    step();

    // Simultaneous reads after reset: CPU first, then DBG wins the repeated tie
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    set_port(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    #1;
    chk("tie1_cpu", {31'h0, cpu_gnt}, 32'h1);
    chk("tie1_dbg", {31'h0, dbg_gnt}, 32'h0);
    step();
    step();
    #1;
    chk("tie2_dbg", {31'h0, dbg_gnt}, 32'h1);
    chk("tie2_cpu", {31'h0, cpu_gnt}, 32'h0);
    step();
    step();
    a_req[1] = 1'b0;
    step();
    step();
    a_req[0] = 1'b0;
    step();

    // Reset during the read-return cycle discards the pending data
    set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    step();
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", {31'h0, cpu_rvalid}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    step();
    rst_n = 1'b1;
    set_port(1, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
    #1;
    chk("rst_tie_cpu", {31'h0, cpu_gnt}, 32'h1);
    step();
    step();
    a_req[0] = 1'b0;
    a_req[1] = 1'b0;
    step();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      drive_random();
      step();
    end

`ifdef DMEM_ARB_ACCESS_CNT_EN
    chk("cnt_cpu",  {16'h0, cpu_gnt_cnt},  (m_cpu_cnt  > 65535) ? 32'hFFFF : 32'(m_cpu_cnt));
    chk("cnt_dbg",  {16'h0, dbg_gnt_cnt},  (m_dbg_cnt  > 65535) ? 32'hFFFF : 32'(m_dbg_cnt));
    chk("cnt_conf", {16'h0, conflict_cnt}, (m_conf_cnt > 65535) ? 32'hFFFF : 32'(m_conf_cnt));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
